// File: rtl/param_data_cache.sv
// Parametrised write-back, write-allocate, set-associative L1 data cache model.
// Tracks valid/dirty/tag/true-LRU age per line, talks to the next level over a
// req/ack handshake and keeps saturating hit/miss/read/write/writeback counts.
module param_data_cache #(
  parameter int ADDR_W      = 32,
  parameter int OFFSET_BITS = 6,
  parameter int SET_BITS    = 14,
  parameter int WAYS        = 4,
  parameter int CNT_W       = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [3:0]                    n,
  input  logic [ADDR_W-1:0]             add_in,
  output logic                          mem_req,
  output logic [1:0]                    mem_cmd,
  output logic [ADDR_W-OFFSET_BITS-1:0] mem_addr,
  input  logic                          mem_ack,
  output logic [CNT_W-1:0]              hit,
  output logic [CNT_W-1:0]              miss,
  output logic [CNT_W-1:0]              reads,
  output logic [CNT_W-1:0]              writes,
  output logic [CNT_W-1:0]              writebacks
);
  localparam int SETS     = 2**SET_BITS;
  localparam int AGE_W    = $clog2(WAYS);
  localparam int TAG_BITS = ADDR_W - SET_BITS - OFFSET_BITS;
  localparam int LINE_W   = ADDR_W - OFFSET_BITS;

  // Command codes; PRINT (9) and unknown codes have no architectural effect.
  localparam logic [3:0] N_READ  = 4'd0;
  localparam logic [3:0] N_WRITE = 4'd1;
  localparam logic [3:0] N_INV   = 4'd3;
  localparam logic [3:0] N_RESET = 4'd8;

  localparam logic [1:0] MC_NOP   = 2'b00;
  localparam logic [1:0] MC_READ  = 2'b01;
  localparam logic [1:0] MC_WRITE = 2'b10;
  localparam logic [1:0] MC_RWITM = 2'b11;

  typedef enum logic [1:0] {IDLE, LOOKUP, WB, FILL} state_t;

  // Reset age row: way i starts with age i, so every set is a valid permutation.
  function automatic logic [WAYS-1:0][AGE_W-1:0] age_init();
    logic [WAYS-1:0][AGE_W-1:0] row;
    for (int w = 0; w < WAYS; w++) row[w] = AGE_W'(w);
    return row;
  endfunction

  localparam logic [WAYS-1:0][AGE_W-1:0] AGE_ROW = age_init();

  // Counter increment that sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t state_q, state_d;

  logic [SETS-1:0][WAYS-1:0]            valid_q;
  logic [SETS-1:0][WAYS-1:0]            dirty_q;
  logic [SETS-1:0][WAYS-1:0][AGE_W-1:0] age_q;
  logic [TAG_BITS-1:0]                  tag_q [SETS][WAYS];

  logic [3:0]        cmd_q;
  logic [LINE_W-1:0] line_q;
  logic [AGE_W-1:0]  way_q;

  logic [SET_BITS-1:0] set_idx;
  logic [TAG_BITS-1:0] tag_in;
  logic                accept, do_clear;
  logic                lk_hit, lk_dirty, inv_found, vic_dirty, touch_en;
  logic [AGE_W-1:0]    lk_way, inv_way, lru_way, vic_way, wb_way, touch_way;

  // Byte-offset bits never matter to a line-granular cache.
  logic unused_offset;
  assign unused_offset = ^add_in[OFFSET_BITS-1:0];

  assign cmd_ready = (state_q == IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;
  assign do_clear  = accept && (n == N_RESET);

  // Lookup, victim choice, LRU touch select and next-state decode.
  always_comb begin
    set_idx   = line_q[SET_BITS-1:0];
    tag_in    = line_q[LINE_W-1 -: TAG_BITS];
    lk_hit    = 1'b0;
    lk_way    = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    lru_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[set_idx][w] && (tag_q[set_idx][w] == tag_in)) begin
        lk_hit = 1'b1;
        lk_way = AGE_W'(w);
      end
      if (age_q[set_idx][w] == AGE_W'(WAYS-1)) lru_way = AGE_W'(w);
    end
    // Descending scan so the lowest-index invalid way wins.
    for (int w = WAYS-1; w >= 0; w--) begin
      if (!valid_q[set_idx][w]) begin
        inv_found = 1'b1;
        inv_way   = AGE_W'(w);
      end
    end
    vic_way   = inv_found ? inv_way : lru_way;
    vic_dirty = valid_q[set_idx][vic_way] && dirty_q[set_idx][vic_way];
    lk_dirty  = dirty_q[set_idx][lk_way];
    wb_way    = (cmd_q == N_INV) ? lk_way : vic_way;
    touch_en  = ((state_q == LOOKUP) && (cmd_q != N_INV) && lk_hit) ||
                ((state_q == FILL) && mem_req && mem_ack);
    touch_way = (state_q == FILL) ? way_q : lk_way;

    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept && ((n == N_READ) || (n == N_WRITE) || (n == N_INV))) state_d = LOOKUP;
      end
      LOOKUP: begin
        if (cmd_q == N_INV)  state_d = (lk_hit && lk_dirty) ? WB : IDLE;
        else if (lk_hit)     state_d = IDLE;
        else if (vic_dirty)  state_d = WB;
        else                 state_d = FILL;
      end
      WB: begin
        if (mem_req && mem_ack) state_d = (cmd_q == N_INV) ? IDLE : FILL;
      end
      FILL: begin
        if (mem_req && mem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register, captured command and registered next-level request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cmd_q    <= '0;
      line_q   <= '0;
      way_q    <= '0;
      mem_req  <= 1'b0;
      mem_cmd  <= MC_NOP;
      mem_addr <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (accept) begin
            cmd_q  <= n;
            line_q <= add_in[ADDR_W-1:OFFSET_BITS];
          end
          if (do_clear) mem_addr <= '0;
        end
        LOOKUP: begin
          if (state_d == WB) begin
            way_q    <= wb_way;
            mem_req  <= 1'b1;
            mem_cmd  <= MC_WRITE;
            mem_addr <= {tag_q[set_idx][wb_way], set_idx};
          end else if (state_d == FILL) begin
            way_q <= vic_way;
          end
        end
        WB: begin
          if (mem_req && mem_ack) begin
            mem_req <= 1'b0;
            mem_cmd <= MC_NOP;
          end
        end
        FILL: begin
          // The fill request is raised one cycle into FILL so a preceding
          // writeback always sees its own req fall before the next one rises.
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_cmd  <= (cmd_q == N_WRITE) ? MC_RWITM : MC_READ;
            mem_addr <= line_q;
          end else if (mem_ack) begin
            mem_req <= 1'b0;
            mem_cmd <= MC_NOP;
          end
        end
        default: ;
      endcase
    end
  end

  // Line metadata: valid/dirty flags and LRU ages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
      age_q   <= {SETS{AGE_ROW}};
    end else if (do_clear) begin
      valid_q <= '0;
      dirty_q <= '0;
      age_q   <= {SETS{AGE_ROW}};
    end else begin
      if ((state_q == LOOKUP) && (cmd_q == N_INV) && lk_hit && !lk_dirty)
        valid_q[set_idx][lk_way] <= 1'b0;
      if ((state_q == LOOKUP) && (cmd_q == N_WRITE) && lk_hit)
        dirty_q[set_idx][lk_way] <= 1'b1;
      if ((state_q == WB) && mem_req && mem_ack && (cmd_q == N_INV)) begin
        valid_q[set_idx][way_q] <= 1'b0;
        dirty_q[set_idx][way_q] <= 1'b0;
      end
      if ((state_q == FILL) && mem_req && mem_ack) begin
        valid_q[set_idx][way_q] <= 1'b1;
        dirty_q[set_idx][way_q] <= (cmd_q == N_WRITE);
      end
      if (touch_en) begin
        for (int w = 0; w < WAYS; w++) begin
          if (AGE_W'(w) == touch_way)
            age_q[set_idx][w] <= '0;
          else if (age_q[set_idx][w] < age_q[set_idx][touch_way])
            age_q[set_idx][w] <= age_q[set_idx][w] + 1'b1;
        end
      end
    end
  end

  // Tag store is plain data: written on fill completion, never reset.
  always_ff @(posedge clk) begin
    if ((state_q == FILL) && mem_req && mem_ack && !rst)
      tag_q[set_idx][way_q] <= tag_in;
  end

  // Saturating statistics, updated at lookup and writeback completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit <= '0; miss <= '0; reads <= '0; writes <= '0; writebacks <= '0;
    end else if (do_clear) begin
      hit <= '0; miss <= '0; reads <= '0; writes <= '0; writebacks <= '0;
    end else begin
      if ((state_q == LOOKUP) && ((cmd_q == N_READ) || (cmd_q == N_WRITE))) begin
        if (cmd_q == N_READ) reads  <= sat_inc(reads);
        else                 writes <= sat_inc(writes);
        if (lk_hit) hit  <= sat_inc(hit);
        else        miss <= sat_inc(miss);
      end
      if ((state_q == WB) && mem_req && mem_ack) writebacks <= sat_inc(writebacks);
    end
  end

endmodule
